// File: rtl/demux_stream_1xn.sv
// 1-to-N stream demultiplexer with a 2-entry in-order skid buffer.
// Each accepted word carries its destination channel. The head entry is offered on the
// shared data bus with a one-hot per-channel valid. Words whose select addresses a
// channel that does not exist are discarded and counted.
module demux_stream_1xn #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CHANNELS  = 8,
    parameter bit          ZERO_IDLE = 1'b1,
    localparam int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [WIDTH-1:0]    y_in,
    input  logic [SEL_W-1:0]    sel_in,
    input  logic                valid_in,
    output logic                ready_out,
    output logic [WIDTH-1:0]    data_out,
    output logic [CHANNELS-1:0] valid_out,
    input  logic [CHANNELS-1:0] ready_in,
    output logic [7:0]          drop_count_out
);

    // One extra bit so a select equal to CHANNELS (power-of-two case) still compares correctly.
    localparam logic [SEL_W:0] CHAN_LIM = (SEL_W + 1)'(CHANNELS);

    // Buffer storage: two slots addressed circularly by a 1-bit head pointer.
    logic [SEL_W-1:0] sel_q  [2];
    logic [WIDTH-1:0] data_q [2];
    logic             head_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic [7:0]       drop_q;
    logic [WIDTH-1:0] last_q;

    logic             full;
    logic             not_empty;
    logic             accept;
    logic             in_range;
    logic             push;
    logic             drop;
    logic             pop;
    logic             wr_idx;
    logic             head_ready;
    logic [SEL_W-1:0] head_sel;
    logic [WIDTH-1:0] head_data;

    // ready_out depends only on the stored count and reset, never on consumer or producer inputs.
    always_comb begin
        full      = (count_q == 2'd2);
        not_empty = (count_q != 2'd0);
        ready_out = ~full & ~rst_in;
        accept    = valid_in & ready_out;
        in_range  = ({1'b0, sel_in} < CHAN_LIM);
        push      = accept & in_range;
        drop      = accept & ~in_range;
        // With one entry stored the free slot is the one after head; with none it is head.
        wr_idx    = head_q ^ count_q[0];
        head_sel  = sel_q[head_q];
        head_data = data_q[head_q];
    end

    // Decode the head destination into the per-channel valid and pick up that channel's ready.
    always_comb begin
        valid_out  = '0;
        head_ready = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (not_empty && head_sel == SEL_W'(i)) begin
                valid_out[i] = 1'b1;
                head_ready   = ready_in[i];
            end
        end
        pop = not_empty & head_ready;
    end

    // Occupancy bookkeeping: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state: count, head pointer, drop counter and last-presented word.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            drop_q  <= 8'd0;
            last_q  <= '0;
        end else begin
            count_q <= count_d;
            if (pop) begin
                head_q <= ~head_q;
            end
            if (drop && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
            // Track what is on the bus so it can be held once the buffer drains.
            if (not_empty) begin
                last_q <= head_data;
            end
        end
    end

    // Payload slots need no reset: they are only observed while count marks them occupied.
    always_ff @(posedge clk_in) begin
        if (push) begin
            sel_q[wr_idx]  <= sel_in;
            data_q[wr_idx] <= y_in;
        end
    end

    // Shared data bus: head word when occupied, otherwise zero or the last word shown.
    always_comb begin
        if (not_empty) begin
            data_out = head_data;
        end else if (ZERO_IDLE) begin
            data_out = '0;
        end else begin
            data_out = last_q;
        end
    end

    assign drop_count_out = drop_q;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Self-checking bench: two instances (8 channels zero-idle, 6 channels hold-last) share
// stimulus. A queue-based reference model is updated at each rising edge; a monitor on
// the falling edge compares every output of both instances against it.
module tb_demux_stream_1xn;

    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [15:0] y_in = '0;
    logic [2:0]  sel_in = '0;
    logic        valid_in = 1'b0;
    logic [7:0]  ready_in = '0;

    logic        ready_a, ready_b;
    logic [15:0] data_a, data_b;
    logic [7:0]  valid_a;
    logic [5:0]  valid_b;
    logic [7:0]  drop_a, drop_b;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, one slot per instance.
    entry_t mq [2][$];
    int     drops [2];
    logic [15:0] last [2];

    always #5 clk = ~clk;

    demux_stream_1xn #(.WIDTH(16), .CHANNELS(8), .ZERO_IDLE(1'b1)) dut_a (
        .clk_in(clk), .rst_in(rst_in), .y_in(y_in), .sel_in(sel_in), .valid_in(valid_in),
        .ready_out(ready_a), .data_out(data_a), .valid_out(valid_a), .ready_in(ready_in),
        .drop_count_out(drop_a)
    );

    demux_stream_1xn #(.WIDTH(16), .CHANNELS(6), .ZERO_IDLE(1'b0)) dut_b (
        .clk_in(clk), .rst_in(rst_in), .y_in(y_in), .sel_in(sel_in), .valid_in(valid_in),
        .ready_out(ready_b), .data_out(data_b), .valid_out(valid_b), .ready_in(ready_in[5:0]),
        .drop_count_out(drop_b)
    );

    function automatic int chans(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: acts on the inputs as they stand at each rising edge.
    initial begin
        for (int k = 0; k < 2; k++) begin
            drops[k] = 0;
            last[k]  = '0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst_in) begin
                    mq[k].delete();
                    drops[k] = 0;
                    last[k]  = '0;
                end else begin
                    bit can_take;
                    can_take = (mq[k].size() < 2);
                    if (mq[k].size() > 0 && ready_in[mq[k][0].sel]) begin
                        last[k] = mq[k][0].data;
                        void'(mq[k].pop_front());
                    end
                    if (valid_in && can_take) begin
                        if (int'(sel_in) < chans(k)) mq[k].push_back('{sel: sel_in, data: y_in});
                        else if (drops[k] < 255) drops[k]++;
                    end
                end
            end
        end
    end

    // Monitor: compare both instances against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic        a_rdy;
                logic [7:0]  a_vld, e_vld, a_drop;
                logic [15:0] a_dat, e_dat;
                a_rdy  = (k == 0) ? ready_a : ready_b;
                a_vld  = (k == 0) ? valid_a : {2'b00, valid_b};
                a_dat  = (k == 0) ? data_a : data_b;
                a_drop = (k == 0) ? drop_a : drop_b;
                e_vld  = '0;
                if (mq[k].size() > 0) begin
                    e_vld[mq[k][0].sel] = 1'b1;
                    e_dat = mq[k][0].data;
                end else begin
                    e_dat = (k == 0) ? 16'h0000 : last[k];
                end
                check($sformatf("ready_out[%0d]", k), 32'(a_rdy),
                      32'(!rst_in && mq[k].size() < 2));
                check($sformatf("valid_out[%0d]", k), 32'(a_vld), 32'(e_vld));
                check($sformatf("data_out[%0d]", k), 32'(a_dat), 32'(e_dat));
                check($sformatf("drop_count[%0d]", k), 32'(a_drop), 32'(drops[k]));
            end
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic word(input logic [2:0] s, input logic [15:0] d);
        valid_in = 1'b1;
        sel_in   = s;
        y_in     = d;
    endtask

    // Stimulus: directed scenarios, then randomized traffic with occasional resets.
    initial begin
        cyc(3);
        rst_in   = 1'b0;
        ready_in = 8'hFF;
        cyc(1);

        // Single word to channel 3.
        word(3'd3, 16'hA5A5);
        cyc(1);
        check("single_valid", 32'(valid_a), 32'h08);
        check("single_data", 32'(data_a), 32'hA5A5);
        valid_in = 1'b0;
        cyc(1);
        check("single_gone", 32'(valid_a), 32'h00);
        cyc(2);

        // Back-to-back stream walking all channels.
        for (int i = 0; i < 8; i++) begin
            word(3'(i), 16'(i + 1));
            cyc(1);
            check("walk_onehot", 32'(valid_a), 32'(1 << i));
        end
        valid_in = 1'b0;
        cyc(3);

        // Backpressure on channel 2.
        ready_in = 8'h00;
        word(3'd2, 16'h0101);
        cyc(1);
        word(3'd2, 16'h0202);
        cyc(1);
        word(3'd2, 16'h0303);
        cyc(3);
        check("bp_full_ready", 32'(ready_a), 32'h0);
        ready_in = 8'h04;
        cyc(2);
        valid_in = 1'b0;
        cyc(4);
        ready_in = 8'hFF;

        // Ready on the wrong channel must not pop.
        ready_in = 8'hDF;
        word(3'd5, 16'h5555);
        cyc(1);
        valid_in = 1'b0;
        cyc(3);
        check("wrong_ready_hold", 32'(valid_a), 32'h20);
        ready_in = 8'hFF;
        cyc(1);
        check("right_ready_pop", 32'(valid_a), 32'h00);
        cyc(2);

        // Out-of-range selects on the 6-channel instance saturate the drop counter.
        for (int i = 0; i < 300; i++) begin
            word((i % 2 == 0) ? 3'd6 : 3'd7, 16'(i));
            cyc(1);
            check("drop_no_valid", 32'(valid_b), 32'h0);
        end
        valid_in = 1'b0;
        cyc(1);
        check("drop_saturate", 32'(drop_b), 32'd255);

        // Reset with two words buffered.
        ready_in = 8'h00;
        word(3'd1, 16'hBEEF);
        cyc(1);
        word(3'd4, 16'hCAFE);
        cyc(1);
        rst_in = 1'b1;
        word(3'd1, 16'hDEAD);
        cyc(1);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_data", 32'(data_b), 32'h0);
        check("rst_drop", 32'(drop_b), 32'h0);
        rst_in   = 1'b0;
        valid_in = 1'b0;
        ready_in = 8'hFF;
        cyc(3);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst_in   = ($urandom_range(0, 149) == 0);
            valid_in = ($urandom_range(0, 3) != 0);
            sel_in   = 3'($urandom);
            y_in     = 16'($urandom);
            ready_in = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            cyc(1);
        end
        rst_in   = 1'b0;
        valid_in = 1'b0;
        ready_in = 8'hFF;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
